// File: rtl/sfifo_pkg.sv
// Shared types and sizing helpers for the single-clock programmable FIFO.
package sfifo_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } fwft_state_e;

  function automatic int f_cntwidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/blockmem_2p.sv
// Simple two-port block memory: port A writes, port B reads with one registered cycle of latency.
module blockmem_2p #(
  parameter int G_DATAWIDTH = 32,
  parameter int G_ADDRWIDTH = 10,
  parameter int G_DEPTH     = 1024
) (
  input  logic                   clka,
  input  logic                   ena,
  input  logic                   wea,
  input  logic [G_ADDRWIDTH-1:0] addra,
  input  logic [G_DATAWIDTH-1:0] dina,
  input  logic                   clkb,
  input  logic                   enb,
  input  logic [G_ADDRWIDTH-1:0] addrb,
  output logic [G_DATAWIDTH-1:0] doutb
);

  logic [G_DATAWIDTH-1:0] mem_q [G_DEPTH];
  logic [G_DATAWIDTH-1:0] doutb_q;

  // write port
  always_ff @(posedge clka) begin
    if (ena && wea) begin
      mem_q[addra] <= dina;
    end
  end

  // registered read port
  always_ff @(posedge clkb) begin
    if (enb) begin
      doutb_q <= mem_q[addrb];
    end
  end

  assign doutb = doutb_q;

endmodule

// File: rtl/sfifo_prog.sv
// Single-clock FIFO with optional first-word-fall-through, any depth >= 2, exact fill count
// and programmable almost-full/almost-empty thresholds.
module sfifo_prog
  import sfifo_pkg::*;
#(
  parameter int G_FWFT      = 0,
  parameter int G_DATAWIDTH = 32,
  parameter int G_MEMDEPTH  = 1024,
  parameter int G_AFULL     = G_MEMDEPTH - 2,
  parameter int G_AEMPTY    = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [G_DATAWIDTH-1:0]               din,
  input  logic                                 wr_en,
  input  logic                                 rd_en,
  output logic [G_DATAWIDTH-1:0]               dout,
  output logic                                 valid,
  output logic                                 full,
  output logic                                 almost_full,
  output logic                                 empty,
  output logic                                 almost_empty,
  output logic                                 overflow,
  output logic                                 underflow,
  output logic [f_cntwidth(G_MEMDEPTH)-1:0]    data_count
);

  localparam int PW = $clog2(G_MEMDEPTH);
  localparam int CW = f_cntwidth(G_MEMDEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(G_MEMDEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(G_MEMDEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(G_AFULL);
  localparam logic [CW-1:0] CNT_AE   = CW'(G_AEMPTY);

  // Depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PTR_LAST) begin
      return '0;
    end else begin
      return ptr + PW'(1);
    end
  endfunction

  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d, mem_cnt_q, mem_cnt_d;
  logic                   stage_v_q, stage_v_d, rd_pend_q, rd_pend_d;
  fwft_state_e            state_q, state_d;
  logic [G_DATAWIDTH-1:0] dout_q, dout_d;
  logic                   valid_q, valid_d, full_q, full_d, afull_q, afull_d;
  logic                   empty_q, empty_d, aempty_q, aempty_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                   wr_acc, rd_acc, load, fetch, ram_rd_en;
  logic [G_DATAWIDTH-1:0] ram_dout;

  blockmem_2p #(
    .G_DATAWIDTH (G_DATAWIDTH),
    .G_ADDRWIDTH (PW),
    .G_DEPTH     (G_MEMDEPTH)
  ) u_mem (
    .clka  (clk),
    .ena   (wr_acc),
    .wea   (1'b1),
    .addra (wr_ptr_q),
    .dina  (din),
    .clkb  (clk),
    .enb   (ram_rd_en),
    .addrb (rd_ptr_q),
    .doutb (ram_dout)
  );

  // next-state: accepts, count, flags and the mode-specific read path
  always_comb begin
    wr_acc    = wr_en & ~full_q;
    rd_acc    = rd_en & ~empty_q;
    load      = 1'b0;
    fetch     = 1'b0;
    ram_rd_en = 1'b0;
    rd_pend_d = 1'b0;
    stage_v_d = stage_v_q;
    mem_cnt_d = mem_cnt_q;
    state_d   = state_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    empty_d   = empty_q;

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (wr_acc) begin
      wr_ptr_d = f_ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (G_FWFT != 0) begin
      // RAM output register acts as a prefetch stage so a pop can be refilled on the same edge.
      load      = stage_v_q & ((state_q == ST_IDLE) | rd_acc);
      fetch     = (mem_cnt_q != CW'(0)) & (~stage_v_q | load);
      ram_rd_en = fetch;
      stage_v_d = fetch | (stage_v_q & ~load);
      case ({wr_acc, fetch})
        2'b10:   mem_cnt_d = mem_cnt_q + CW'(1);
        2'b01:   mem_cnt_d = mem_cnt_q - CW'(1);
        default: mem_cnt_d = mem_cnt_q;
      endcase
      if (load) begin
        state_d = ST_VALID;
        dout_d  = ram_dout;
      end else if (rd_acc) begin
        state_d = ST_IDLE;
      end else begin
        state_d = state_q;
      end
      valid_d = (state_d == ST_VALID);
      empty_d = (state_d != ST_VALID);
    end else begin
      ram_rd_en = rd_acc;
      rd_pend_d = rd_acc;
      valid_d   = rd_pend_q;
      empty_d   = (count_d == CW'(0));
      if (rd_pend_q) begin
        dout_d = ram_dout;
      end else begin
        dout_d = dout_q;
      end
    end

    if (ram_rd_en) begin
      rd_ptr_d = f_ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    full_d   = (count_d == CNT_FULL);
    afull_d  = (count_d >= CNT_AF);
    aempty_d = (count_d <= CNT_AE);
    ovf_d    = wr_en & full_q;
    unf_d    = rd_en & empty_q;
  end

  // state registers with asynchronous reset; RAM contents are left alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_cnt_q <= '0;
      stage_v_q <= 1'b0;
      rd_pend_q <= 1'b0;
      state_q   <= ST_IDLE;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mem_cnt_q <= mem_cnt_d;
      stage_v_q <= stage_v_d;
      rd_pend_q <= rd_pend_d;
      state_q   <= state_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign dout         = dout_q;
  assign valid        = valid_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;
  assign data_count   = count_q;

endmodule
